// File: rtl/icc_pkg.sv
// Shared definitions for the inter-chassis TX lane scheduler.
//   K_COMMA / K_ALIGNREQ : K-words placed on the 16-bit lane (K28.5 in the low byte)
//   K_ISK                : charisk value for those K-words
//   ACTW / MSGBYTES      : action code width and bytes per message
//   icc_txst_t           : scheduler state
//   msg_word()           : frames one message byte as {action, index, byte}
package icc_pkg;

  localparam logic [15:0] K_COMMA    = 16'h00BC;
  localparam logic [15:0] K_ALIGNREQ = 16'h01BC;
  localparam logic [1:0]  K_ISK      = 2'b01;
  localparam int          ACTW       = 5;
  localparam int          MSGBYTES   = 8;

  typedef enum logic [1:0] {IDLE, SEND, CC} icc_txst_t;

  // Byte idx of the message, counted from the most significant byte.
  function automatic logic [15:0] msg_word(input logic [ACTW-1:0]       act,
                                           input logic [2:0]            idx,
                                           input logic [8*MSGBYTES-1:0] msg);
    logic [2:0] sel;
    sel = 3'd7 - idx;
    return {act, idx, msg[{sel, 3'b000} +: 8]};
  endfunction

endpackage

// File: rtl/icc_rr_arb.sv
// Combinational round-robin picker.
//   req    in  NREQ  pending requests
//   rr_ptr in  PW    last requester served; search starts at rr_ptr+1 mod NREQ
//   grant  out NREQ  one-hot winner (all zero when nothing is requested)
//   index  out PW    binary index of the winner
module icc_rr_arb #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   index
);

  always_comb begin
    int          j;
    logic [PW-1:0] jj;
    logic        found;
    grant = '0;
    index = '0;
    found = 1'b0;
    j     = 0;
    jj    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      jj = PW'(j);
      if (!found && req[jj]) begin
        found     = 1'b1;
        grant[jj] = 1'b1;
        index     = jj;
      end
    end
  end

endmodule

// File: rtl/icc_tx_sched.sv
// Scheduler for the 16-bit GT inter-chassis TX lane. Shares the lane between
// NREQ message requesters, frames 8-byte messages as {action,index,byte}
// words, and fills every other cycle with alignment requests, commas and
// periodic clock-correction comma bursts. All outputs are registered.
//   txclk           in   GT TX user clock
//   reset_n         in   asynchronous active-low reset
//   rxbyteisaligned in   local RX byte-aligned (txclk domain)
//   alignrequest    in   peer requests commas (txclk domain)
//   req             in   per-requester message pending, held until done
//   action          in   per-requester 5-bit action, slice [5i+:5]
//   msgdata         in   per-requester 64-bit message, slice [64i+:64], MSB byte first
//   gnt             out  pulse with byte 0 of message i on txdata
//   done            out  pulse with byte 7 of message i on txdata
//   txdata          out  to gticc.txdata
//   txcharisk       out  to gticc.txcharisk
//   busy            out  message in flight
module icc_tx_sched
  import icc_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int CCPERIOD = 4096,
  parameter int CCLEN    = 2
) (
  input  logic                 txclk,
  input  logic                 reset_n,
  input  logic                 rxbyteisaligned,
  input  logic                 alignrequest,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*ACTW-1:0] action,
  input  logic [NREQ*64-1:0]   msgdata,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [15:0]          txdata,
  output logic [1:0]           txcharisk,
  output logic                 busy
);

  localparam int PW  = $clog2(NREQ);
  localparam int CCW = $clog2(CCPERIOD);
  localparam int CLW = $clog2(CCLEN) + 1;

  icc_txst_t        state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [PW-1:0]    cur_q, cur_d;
  logic [NREQ-1:0]  cur_oh_q, cur_oh_d;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CCW-1:0]   cc_cnt_q, cc_cnt_d;
  logic             cc_pend_q, cc_pend_d;
  logic [CLW-1:0]   ccw_q, ccw_d;
  logic [15:0]      txdata_q, txdata_d;
  logic [1:0]       txcharisk_q, txcharisk_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [NREQ-1:0]  done_q, done_d;
  logic             busy_q, busy_d;
  logic [ACTW-1:0]  act_q, act_d;
  logic [63:0]      msg_q, msg_d;

  logic [NREQ-1:0]  arb_grant;
  logic [PW-1:0]    arb_idx;
  logic [ACTW-1:0]  act_arr [NREQ];
  logic [63:0]      msg_arr [NREQ];
  logic             cc_wrap;
  logic             cc_due;

  icc_rr_arb #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .grant  (arb_grant),
    .index  (arb_idx)
  );

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      act_arr[i] = action[ACTW*i +: ACTW];
      msg_arr[i] = msgdata[64*i +: 64];
    end
  end

  // The wrap cycle itself already counts as pending so that a burst falling
  // due in the same cycle as a request takes precedence over it.
  assign cc_wrap  = (cc_cnt_q == CCW'(CCPERIOD - 1));
  assign cc_due   = cc_pend_q | cc_wrap;
  assign cc_cnt_d = cc_wrap ? '0 : cc_cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cur_d       = cur_q;
    cur_oh_d    = cur_oh_q;
    rr_ptr_d    = rr_ptr_q;
    ccw_d       = ccw_q;
    cc_pend_d   = cc_pend_q | cc_wrap;
    act_d       = act_q;
    msg_d       = msg_q;
    gnt_d       = '0;
    done_d      = '0;
    txdata_d    = rxbyteisaligned ? K_COMMA : K_ALIGNREQ;
    txcharisk_d = K_ISK;

    case (state_q)
      // The cycle that latches a message still emits a comma, which keeps
      // at least one comma between consecutive messages.
      IDLE: begin
        if (rxbyteisaligned && !alignrequest) begin
          if (cc_due) begin
            state_d = CC;
            ccw_d   = '0;
          end else if (|req) begin
            state_d  = SEND;
            idx_d    = 3'd0;
            cur_d    = arb_idx;
            cur_oh_d = arb_grant;
            act_d    = act_arr[arb_idx];
            msg_d    = msg_arr[arb_idx];
          end
        end
      end

      // Misalignment aborts without done and without moving rr_ptr, so the
      // same requester is served again from byte 0. alignrequest only holds idx.
      SEND: begin
        if (!rxbyteisaligned) begin
          state_d = IDLE;
        end else if (!alignrequest) begin
          txdata_d    = msg_word(act_q, idx_q, msg_q);
          txcharisk_d = 2'b00;
          if (idx_q == 3'd0) gnt_d = cur_oh_q;
          if (idx_q == 3'd7) begin
            done_d   = cur_oh_q;
            rr_ptr_d = cur_q;
            state_d  = IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end

      CC: begin
        if (!rxbyteisaligned) begin
          state_d = IDLE;
        end else if (ccw_q == CLW'(CCLEN - 1)) begin
          state_d   = IDLE;
          cc_pend_d = cc_wrap;
        end else begin
          ccw_d = ccw_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SEND);
  end

  always_ff @(posedge txclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cur_q       <= '0;
      cur_oh_q    <= '0;
      rr_ptr_q    <= PW'(NREQ - 1);
      cc_cnt_q    <= '0;
      cc_pend_q   <= 1'b0;
      ccw_q       <= '0;
      txdata_q    <= K_ALIGNREQ;
      txcharisk_q <= K_ISK;
      gnt_q       <= '0;
      done_q      <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cur_q       <= cur_d;
      cur_oh_q    <= cur_oh_d;
      rr_ptr_q    <= rr_ptr_d;
      cc_cnt_q    <= cc_cnt_d;
      cc_pend_q   <= cc_pend_d;
      ccw_q       <= ccw_d;
      txdata_q    <= txdata_d;
      txcharisk_q <= txcharisk_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  always_ff @(posedge txclk) begin
    act_q <= act_d;
    msg_q <= msg_d;
  end

  assign txdata    = txdata_q;
  assign txcharisk = txcharisk_q;
  assign gnt       = gnt_q;
  assign done      = done_q;
  assign busy      = busy_q;

endmodule
